rf_write_arbiter: RTL and testbench



---
 rtl/rf_write_arbiter.sv | 142 ++++++++++++++
 tb/tb_rf_write_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Shares the register file's single write port among ALU writeback (0), memory load (1)
// and host loader (2): round-robin grants, requester-2 burst lock, registered write stage.
module rf_write_arbiter #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic              i_clk,
    input  logic              i_rstbar,
    input  logic [2:0]        i_req,
    input  logic [3*AW-1:0]   i_req_wa,
    input  logic [3*DW-1:0]   i_req_wd,
    input  logic              i_lock,
    input  logic              i_hold,
    output logic [2:0]        o_ack,
    output logic              o_webar,
    output logic [AW-1:0]     o_wa,
    output logic [DW-1:0]     o_wd,
    output logic [1:0]        o_last_gnt,
    output logic [15:0]       o_wcount
);

    typedef enum logic {
        ST_RR     = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t        r_state;
    logic          r_webar_p1;
    logic [AW-1:0] r_wa_p1;
    logic [DW-1:0] r_wd_p1;
    logic [1:0]    r_last_gnt;
    logic [15:0]   r_wcount;

    logic [2:0]    w_ack;
    logic [2:0]    w_grant;
    logic          w_xfer;
    logic [1:0]    w_idx;
    logic [AW-1:0] w_sel_wa;
    logic [DW-1:0] w_sel_wd;

    // Search starts one past the last grant and wraps 2 -> 0; first requester found wins.
    function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [2:0] gnt;
        logic [1:0] idx;
        gnt = 3'b000;
        idx = (last >= 2'd2) ? 2'd0 : last + 2'd1;
        for (int k = 0; k < 3; k++) begin
            if (gnt == 3'b000 && req[idx]) begin
                gnt[idx] = 1'b1;
            end
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
        return gnt;
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [2:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        if (oh[1]) idx = 2'd1;
        if (oh[2]) idx = 2'd2;
        return idx;
    endfunction

    always_comb begin
        w_ack = 3'b000;
        if (i_rstbar && !i_hold) begin
            if (r_state == ST_LOCKED) begin
                // Dropping LOCK in a burst releases the port without a final transfer.
                w_ack[2] = i_req[2] & i_lock;
            end else begin
                w_ack = rr_pick(i_req, r_last_gnt);
            end
        end
    end

    assign w_grant = i_req & w_ack;
    assign w_xfer  = |w_grant;
    assign w_idx   = onehot_idx(w_grant);

    always_comb begin
        w_sel_wa = i_req_wa[AW-1:0];
        w_sel_wd = i_req_wd[DW-1:0];
        case (w_idx)
            2'd1: begin
                w_sel_wa = i_req_wa[2*AW-1:AW];
                w_sel_wd = i_req_wd[2*DW-1:DW];
            end
            2'd2: begin
                w_sel_wa = i_req_wa[3*AW-1:2*AW];
                w_sel_wd = i_req_wd[3*DW-1:2*DW];
            end
            default: begin
                w_sel_wa = i_req_wa[AW-1:0];
                w_sel_wd = i_req_wd[DW-1:0];
            end
        endcase
    end

    // p0 -> p1: accepted request registered onto the RF write port
    always_ff @(posedge i_clk) begin
        if (!i_rstbar) begin
            r_state    <= ST_RR;
            r_webar_p1 <= 1'b1;
            r_wa_p1    <= '0;
            r_wd_p1    <= '0;
            r_last_gnt <= 2'd2;
            r_wcount   <= 16'd0;
        end else begin
            r_webar_p1 <= ~w_xfer;
            if (w_xfer) begin
                r_wa_p1    <= w_sel_wa;
                r_wd_p1    <= w_sel_wd;
                r_last_gnt <= w_idx;
                r_wcount   <= r_wcount + 16'd1;
            end
            // HOLD freezes the state; the pointer is frozen because nothing is accepted.
            if (!i_hold) begin
                case (r_state)
                    ST_RR: begin
                        if (w_xfer && w_idx == 2'd2 && i_lock) begin
                            r_state <= ST_LOCKED;
                        end
                    end
                    ST_LOCKED: begin
                        if (!i_req[2] || !i_lock) begin
                            r_state <= ST_RR;
                        end
                    end
                    default: r_state <= ST_RR;
                endcase
            end
        end
    end

    assign o_ack      = w_ack;
    assign o_webar    = r_webar_p1;
    assign o_wa       = r_wa_p1;
    assign o_wd       = r_wd_p1;
    assign o_last_gnt = r_last_gnt;
    assign o_wcount   = r_wcount;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: expected writes are queued when a grant is
// driven and checked against the registered RF port one cycle later.
module tb_rf_write_arbiter;

    localparam int DW = 16;
    localparam int AW = 4;

    logic              clk = 1'b0;
    logic              i_rstbar;
    logic [2:0]        i_req;
    logic [3*AW-1:0]   i_req_wa;
    logic [3*DW-1:0]   i_req_wd;
    logic              i_lock;
    logic              i_hold;
    logic [2:0]        o_ack;
    logic              o_webar;
    logic [AW-1:0]     o_wa;
    logic [DW-1:0]     o_wd;
    logic [1:0]        o_last_gnt;
    logic [15:0]       o_wcount;

    typedef struct packed {
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } wr_t;

    wr_t         sb[$];
    bit [DW-1:0] rf [16];
    int          n_pass = 0;
    int          n_total = 0;
    logic [15:0] exp_wcount;
    logic [1:0]  exp_last;

    always #5 clk = ~clk;

    rf_write_arbiter #(.DW(DW), .AW(AW)) dut (
        .i_clk      (clk),
        .i_rstbar   (i_rstbar),
        .i_req      (i_req),
        .i_req_wa   (i_req_wa),
        .i_req_wd   (i_req_wd),
        .i_lock     (i_lock),
        .i_hold     (i_hold),
        .o_ack      (o_ack),
        .o_webar    (o_webar),
        .o_wa       (o_wa),
        .o_wd       (o_wd),
        .o_last_gnt (o_last_gnt),
        .o_wcount   (o_wcount)
    );

    // Register file model: writes on edges where the arbiter drives WEBAR low.
    always @(posedge clk) begin
        if (o_webar == 1'b0) rf[o_wa] <= o_wd;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        i_req_wa[i*AW +: AW] = wa;
        i_req_wd[i*DW +: DW] = wd;
    endtask

    // Called #1 after a rising edge; drives one cycle and checks the result after the next edge.
    task automatic step(input logic [2:0] req, input logic lock, input logic hold,
                        input logic [2:0] exp_ack, input string tag);
        wr_t  e;
        wr_t  got;
        int   idx;
        logic xfer;
        i_req  = req;
        i_lock = lock;
        i_hold = hold;
        #1;
        check({tag, "_ack"}, 32'(o_ack), 32'(exp_ack));
        xfer = |(req & exp_ack);
        idx  = exp_ack[2] ? 2 : (exp_ack[1] ? 1 : 0);
        if (xfer) begin
            e.wa = i_req_wa[idx*AW +: AW];
            e.wd = i_req_wd[idx*DW +: DW];
            sb.push_back(e);
            exp_wcount++;
            exp_last = 2'(idx);
        end
        @(posedge clk);
        #1;
        check({tag, "_webar"}, 32'(o_webar), 32'(!xfer));
        if (xfer) begin
            got.wa = o_wa;
            got.wd = o_wd;
            e = sb.pop_front();
            check({tag, "_wr"}, 32'(got), 32'(e));
        end
        check({tag, "_wcount"}, 32'(o_wcount), 32'(exp_wcount));
        check({tag, "_last"}, 32'(o_last_gnt), 32'(exp_last));
    endtask

    initial begin
        int n;
        i_rstbar = 1'b0;
        i_req    = 3'b111;
        i_lock   = 1'b0;
        i_hold   = 1'b0;
        for (int i = 0; i < 3; i++) set_src(i, AW'(i + 1), DW'(100 + i));
        exp_wcount = 16'd0;
        exp_last   = 2'd2;

        // Reset with all requesters asking
        #1;
        check("rst_ack_pre", 32'(o_ack), 32'(3'b000));
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(o_ack), 32'(3'b000));
        check("rst_webar", 32'(o_webar), 32'(1'b1));
        check("rst_wcount", 32'(o_wcount), 32'(16'd0));
        check("rst_last", 32'(o_last_gnt), 32'(2'd2));
        i_rstbar = 1'b1;

        // Round-robin with all three requesting
        step(3'b111, 1'b0, 1'b0, 3'b001, "rr0");
        step(3'b111, 1'b0, 1'b0, 3'b010, "rr1");
        step(3'b111, 1'b0, 1'b0, 3'b100, "rr2");
        step(3'b111, 1'b0, 1'b0, 3'b001, "rr3");
        step(3'b111, 1'b0, 1'b0, 3'b010, "rr4");
        step(3'b111, 1'b0, 1'b0, 3'b100, "rr5");
        check("rr_wcount6", 32'(o_wcount), 32'(16'd6));

        // Lock burst from requester 2 while requester 0 keeps asking
        step(3'b101, 1'b1, 1'b0, 3'b001, "lk_pre");
        set_src(2, 4'd8, 16'd31884);
        step(3'b101, 1'b1, 1'b0, 3'b100, "lk_b0");
        set_src(2, 4'd15, 16'd2222);
        step(3'b101, 1'b1, 1'b0, 3'b100, "lk_b1");
        set_src(2, 4'd14, 16'd10943);
        step(3'b101, 1'b1, 1'b0, 3'b100, "lk_b2");
        set_src(2, 4'd1, 16'd20);
        step(3'b101, 1'b1, 1'b0, 3'b100, "lk_b3");
        step(3'b001, 1'b1, 1'b0, 3'b000, "lk_unlock");
        step(3'b001, 1'b1, 1'b0, 3'b001, "lk_after");
        check("lk_rf14", 32'(rf[14]), 32'(16'd10943));
        check("lk_rf8", 32'(rf[8]), 32'(16'd31884));

        // HOLD for three cycles mid-traffic
        step(3'b111, 1'b0, 1'b0, 3'b010, "hd_pre");
        step(3'b111, 1'b0, 1'b1, 3'b000, "hd0");
        step(3'b111, 1'b0, 1'b1, 3'b000, "hd1");
        step(3'b111, 1'b0, 1'b1, 3'b000, "hd2");
        step(3'b111, 1'b0, 1'b0, 3'b100, "hd_resume");

        // Collision on R5 starting from LAST_GNT=2
        set_src(0, 4'd5, 16'h1111);
        set_src(1, 4'd5, 16'h2222);
        step(3'b011, 1'b0, 1'b0, 3'b001, "col0");
        step(3'b010, 1'b0, 1'b0, 3'b010, "col1");
        step(3'b000, 1'b0, 1'b0, 3'b000, "col_idle");
        check("col_rf5", 32'(rf[5]), 32'(16'h2222));

        // Preload the write counter up to 0xFFFF, then wrap it
        n = int'(16'hFFFF - exp_wcount);
        i_req = 3'b001;
        repeat (n) @(posedge clk);
        #1;
        i_req = 3'b000;
        @(posedge clk);
        #1;
        exp_wcount = 16'hFFFF;
        exp_last   = 2'd0;
        check("wrap_ffff", 32'(o_wcount), 32'(16'hFFFF));
        set_src(0, 4'd3, 16'hABCD);
        step(3'b001, 1'b0, 1'b0, 3'b001, "wrap");
        check("wrap_zero", 32'(o_wcount), 32'(16'h0000));

        // Reset right after an accept cancels the registered state
        step(3'b001, 1'b0, 1'b0, 3'b001, "rm_acc");
        i_rstbar = 1'b0;
        @(posedge clk);
        #1;
        check("rm_webar", 32'(o_webar), 32'(1'b1));
        check("rm_wa", 32'(o_wa), 32'(4'd0));
        check("rm_wd", 32'(o_wd), 32'(16'd0));
        check("rm_wcount", 32'(o_wcount), 32'(16'd0));
        check("rm_last", 32'(o_last_gnt), 32'(2'd2));

        // A request presented at a reset edge is dropped and never reaches the RF
        set_src(0, 4'd9, 16'hBEEF);
        check("rd_ack", 32'(o_ack), 32'(3'b000));
        @(posedge clk);
        #1;
        check("rd_webar", 32'(o_webar), 32'(1'b1));
        i_req = 3'b000;
        @(posedge clk);
        #1;
        check("rd_rf9", 32'(rf[9]), 32'(16'd0));
        i_rstbar   = 1'b1;
        exp_wcount = 16'd0;
        exp_last   = 2'd2;
        step(3'b001, 1'b0, 1'b0, 3'b001, "post_rst");
        step(3'b000, 1'b0, 1'b0, 3'b000, "post_idle");
        check("post_rf9", 32'(rf[9]), 32'(16'hBEEF));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
